// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared instruction types and queue constants for instr_queue
package instr_queue_pkg;

    localparam int IQ_ADDR_WIDTH = 18;

    localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd0;
    localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
    localparam logic [1:0] INSTR_TYPE_LD_ST      = 2'd2;
    localparam logic [1:0] INSTR_TYPE_RESERVED   = 2'd3;

    typedef struct packed {
        logic [IQ_ADDR_WIDTH-1:0] main_mem_addr;
        logic [IQ_ADDR_WIDTH-1:0] cache_addr;
        logic [8:0]               op;
    } dma_instruction;

    typedef struct packed {
        logic [13:0] op;
    } arithmetic_instruction;

    typedef struct packed {
        logic [IQ_ADDR_WIDTH-1:0] cache_addr;
        logic [9:0]               op;
    } regfile_instruction;

endpackage

// File: rtl/instr_replicator.sv
// rtl/instr_replicator.sv - copy counter and per-copy address generation (INSTR_QUEUE_ADDR_STRIDE_EN)
module instr_replicator #(
    parameter int CW = 4,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue,
    input  logic [CW-1:0] copy_count,
    input  logic [AW-1:0] base_cache_addr,
    input  logic [AW-1:0] base_main_mem_addr,
    input  logic [AW-1:0] d_cache_addr,
    input  logic [AW-1:0] d_main_mem_addr,
    output logic [AW-1:0] cur_cache_addr,
    output logic [AW-1:0] cur_main_mem_addr,
    output logic          last_copy
);

    logic [CW-1:0] copy_idx;

    assign last_copy = (copy_idx == copy_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            copy_idx <= '0;
        end else if (issue) begin
            copy_idx <= last_copy ? '0 : copy_idx + 1'b1;
        end
    end

`ifdef INSTR_QUEUE_ADDR_STRIDE_EN
    logic [AW-1:0] cache_acc;
    logic [AW-1:0] main_acc;

    // Copy 0 takes the entry's base directly, so a fresh head never sees stale sums.
    assign cur_cache_addr    = (copy_idx == '0) ? base_cache_addr    : cache_acc;
    assign cur_main_mem_addr = (copy_idx == '0) ? base_main_mem_addr : main_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_acc <= '0;
            main_acc  <= '0;
        end else if (issue) begin
            cache_acc <= cur_cache_addr + d_cache_addr;
            main_acc  <= cur_main_mem_addr + d_main_mem_addr;
        end
    end
`else
    logic unused_stride;
    assign unused_stride     = ^{d_cache_addr, d_main_mem_addr};
    assign cur_cache_addr    = base_cache_addr;
    assign cur_main_mem_addr = base_main_mem_addr;
`endif

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order replicating issue FIFO (INSTR_QUEUE_ADDR_STRIDE_EN enables address strides)
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int LOG_DEPTH             = 3,
    parameter int ADDR_WIDTH            = IQ_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             re,
    output dma_instruction                   dma_instr,
    output arithmetic_instruction            arithmetic_instr,
    output regfile_instruction               cache_instr,
    output logic                             empty,
    input  logic                             we,
    input  logic [1:0]                       instr_type,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]   copy_count,
    input  logic [ADDR_WIDTH-1:0]            cache_addr,
    input  logic [ADDR_WIDTH-1:0]            main_mem_addr,
    input  logic [ADDR_WIDTH-1:0]            d_cache_addr,
    input  logic [ADDR_WIDTH-1:0]            d_main_mem_addr,
    input  logic [13:0]                      in_arith_instr,
    input  logic [8:0]                       in_ram_instr,
    input  logic [9:0]                       in_ld_st_instr
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_SUPERSCALAR_WIDTH + 1;

    logic [1:0]            type_q  [DEPTH];
    logic [13:0]           arith_q [DEPTH];
    logic [8:0]            ram_q   [DEPTH];
    logic [9:0]            ldst_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] cache_q [DEPTH];
    logic [ADDR_WIDTH-1:0] main_q  [DEPTH];
    logic [CW-1:0]         cc_q    [DEPTH];

    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic [LOG_DEPTH:0]    count;

    logic                  issue;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  last_copy;
    logic [ADDR_WIDTH-1:0] head_d_cache;
    logic [ADDR_WIDTH-1:0] head_d_main;
    logic [ADDR_WIDTH-1:0] cur_cache_addr;
    logic [ADDR_WIDTH-1:0] cur_main_mem_addr;

    assign empty = (count == '0);
    assign full  = (count == (LOG_DEPTH+1)'(DEPTH));
    assign issue = re && !empty;
    assign pop   = issue && last_copy;
    // A pop in the same cycle frees the slot, so a full queue may still accept.
    assign push  = we && (instr_type != INSTR_TYPE_RESERVED) && (!full || pop);

`ifdef INSTR_QUEUE_ADDR_STRIDE_EN
    logic [ADDR_WIDTH-1:0] dc_q [DEPTH];
    logic [ADDR_WIDTH-1:0] dm_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            dc_q[wr_ptr] <= d_cache_addr;
            dm_q[wr_ptr] <= d_main_mem_addr;
        end
    end

    assign head_d_cache = dc_q[rd_ptr];
    assign head_d_main  = dm_q[rd_ptr];
`else
    logic unused_d_inputs;
    assign unused_d_inputs = ^{d_cache_addr, d_main_mem_addr};
    assign head_d_cache    = '0;
    assign head_d_main     = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            type_q[wr_ptr]  <= instr_type;
            arith_q[wr_ptr] <= in_arith_instr;
            ram_q[wr_ptr]   <= in_ram_instr;
            ldst_q[wr_ptr]  <= in_ld_st_instr;
            cache_q[wr_ptr] <= cache_addr;
            main_q[wr_ptr]  <= main_mem_addr;
            cc_q[wr_ptr]    <= copy_count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    instr_replicator #(
        .CW (CW),
        .AW (ADDR_WIDTH)
    ) u_replicator (
        .clk                (clk),
        .reset              (reset),
        .issue              (issue),
        .copy_count         (cc_q[rd_ptr]),
        .base_cache_addr    (cache_q[rd_ptr]),
        .base_main_mem_addr (main_q[rd_ptr]),
        .d_cache_addr       (head_d_cache),
        .d_main_mem_addr    (head_d_main),
        .cur_cache_addr     (cur_cache_addr),
        .cur_main_mem_addr  (cur_main_mem_addr),
        .last_copy          (last_copy)
    );

    // Only the head's type port carries the copy; the other two read as NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_instr        <= '0;
            arithmetic_instr <= '0;
            cache_instr      <= '0;
        end else if (issue) begin
            dma_instr        <= '0;
            arithmetic_instr <= '0;
            cache_instr      <= '0;
            case (type_q[rd_ptr])
                INSTR_TYPE_ARITHMETIC: arithmetic_instr.op <= arith_q[rd_ptr];
                INSTR_TYPE_RAM: begin
                    dma_instr.main_mem_addr <= cur_main_mem_addr;
                    dma_instr.cache_addr    <= cur_cache_addr;
                    dma_instr.op            <= ram_q[rd_ptr];
                end
                INSTR_TYPE_LD_ST: begin
                    cache_instr.cache_addr <= cur_cache_addr;
                    cache_instr.op         <= ldst_q[rd_ptr];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed vector bench for instr_queue
module tb_instr_queue;
    import instr_queue_pkg::*;

`ifdef INSTR_QUEUE_ADDR_STRIDE_EN
    localparam bit STR = 1'b1;
`else
    localparam bit STR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  re = 1'b0;
    logic                  we = 1'b0;
    logic [1:0]            instr_type = '0;
    logic [3:0]            copy_count = '0;
    logic [17:0]           cache_addr = '0;
    logic [17:0]           main_mem_addr = '0;
    logic [17:0]           d_cache_addr = '0;
    logic [17:0]           d_main_mem_addr = '0;
    logic [13:0]           in_arith_instr = '0;
    logic [8:0]            in_ram_instr = '0;
    logic [9:0]            in_ld_st_instr = '0;
    dma_instruction        dma_instr;
    arithmetic_instruction arithmetic_instr;
    regfile_instruction    cache_instr;
    logic                  empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_queue dut (
        .clk              (clk),
        .reset            (reset),
        .re               (re),
        .dma_instr        (dma_instr),
        .arithmetic_instr (arithmetic_instr),
        .cache_instr      (cache_instr),
        .empty            (empty),
        .we               (we),
        .instr_type       (instr_type),
        .copy_count       (copy_count),
        .cache_addr       (cache_addr),
        .main_mem_addr    (main_mem_addr),
        .d_cache_addr     (d_cache_addr),
        .d_main_mem_addr  (d_main_mem_addr),
        .in_arith_instr   (in_arith_instr),
        .in_ram_instr     (in_ram_instr),
        .in_ld_st_instr   (in_ld_st_instr)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  typ;
        logic [3:0]  cc;
        logic [17:0] ca;
        logic [17:0] ma;
        logic [17:0] dc;
        logic [17:0] dm;
        logic [13:0] pl;
        logic        re;
        logic        e_empty;
        logic [13:0] e_ar;
        logic [44:0] e_dma;
        logic [27:0] e_cache;
    } vec_t;

    function automatic vec_t mk(logic w, logic [1:0] t, logic [3:0] c, logic [17:0] ca, logic [17:0] ma,
                                logic [17:0] dc, logic [17:0] dm, logic [13:0] pl, logic r,
                                logic ee, logic [13:0] ear, logic [44:0] edma, logic [27:0] ecache);
        vec_t v;
        v.we = w; v.typ = t; v.cc = c; v.ca = ca; v.ma = ma; v.dc = dc; v.dm = dm; v.pl = pl;
        v.re = r; v.e_empty = ee; v.e_ar = ear; v.e_dma = edma; v.e_cache = ecache;
        return v;
    endfunction

    function automatic logic [44:0] dma_v(logic [17:0] m, logic [17:0] c, logic [8:0] op);
        return {m, c, op};
    endfunction

    function automatic logic [27:0] ld_v(logic [17:0] c, logic [9:0] op);
        return {c, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] t, input logic [3:0] c, input logic [17:0] ca,
                         input logic [17:0] dc, input logic [13:0] pl, input logic r);
        we = w; instr_type = t; copy_count = c; cache_addr = ca; main_mem_addr = '0;
        d_cache_addr = dc; d_main_mem_addr = '0;
        in_arith_instr = pl; in_ram_instr = pl[8:0]; in_ld_st_instr = pl[9:0]; re = r;
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 20, 0, 0, 0,  '0, '0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 20, '0, '0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 20, '0, '0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 20, '0, '0);
        vecs[4]  = mk(1, 1, 2, 18'h10, 18'h100, 4, 18'h40, 45, 0, 0, 20, '0, '0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, dma_v(18'h100, 18'h10, 45), '0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,
                      dma_v(STR ? 18'h140 : 18'h100, STR ? 18'h14 : 18'h10, 45), '0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,
                      dma_v(STR ? 18'h180 : 18'h100, STR ? 18'h18 : 18'h10, 45), '0);
        vecs[8]  = mk(1, 2, 0, 18'h22, 0, 0, 0, 7, 0, 0, 0, vecs[7].e_dma, '0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 3,  1, 0, 0, '0, ld_v(18'h22, 7));
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 3, '0, '0);
        vecs[11] = mk(1, 2, 1, 18'h3FFFF, 0, 1, 0, 5, 0, 0, 3, '0, '0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, '0, ld_v(18'h3FFFF, 5));
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, '0, ld_v(STR ? 18'h0 : 18'h3FFFF, 5));
        vecs[14] = mk(1, 3, 0, 0, 0, 0, 0, 99, 0, 1, 0, '0, vecs[13].e_cache);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, '0, vecs[13].e_cache);

        step();
        step();
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_dma", 64'(dma_instr), 64'd0);
        chk("reset_arith", 64'(arithmetic_instr), 64'd0);
        chk("reset_cache", 64'(cache_instr), 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            we = vecs[i].we; instr_type = vecs[i].typ; copy_count = vecs[i].cc;
            cache_addr = vecs[i].ca; main_mem_addr = vecs[i].ma;
            d_cache_addr = vecs[i].dc; d_main_mem_addr = vecs[i].dm;
            in_arith_instr = vecs[i].pl; in_ram_instr = vecs[i].pl[8:0]; in_ld_st_instr = vecs[i].pl[9:0];
            re = vecs[i].re;
            step();
            chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_empty));
            chk($sformatf("vec%0d_arith", i), 64'(arithmetic_instr), 64'(vecs[i].e_ar));
            chk($sformatf("vec%0d_dma", i), 64'(dma_instr), 64'(vecs[i].e_dma));
            chk($sformatf("vec%0d_cache", i), 64'(cache_instr), 64'(vecs[i].e_cache));
        end

        // Overflow: nine pushes, the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, 0, 14'(100 + i), 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_not_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 8; i++) begin
            re = 1'b1;
            step();
            chk($sformatf("ovf_drain%0d", i), 64'(arithmetic_instr), 64'(100 + i));
            chk($sformatf("ovf_empty%0d", i), 64'(empty), 64'(i == 7));
        end
        step();
        chk("ovf_hold", 64'(arithmetic_instr), 64'd107);
        re = 1'b0;

        // Push while full with a same-cycle pop is accepted.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 14'(50 + i), 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 60, 1);
        step();
        chk("fullpop_first", 64'(arithmetic_instr), 64'd50);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("fullpop_drain%0d", i), 64'(arithmetic_instr), 64'((i < 8) ? 50 + i : 60));
        end
        chk("fullpop_empty", 64'(empty), 64'd1);
        re = 1'b0;

        // Reset in the middle of a replay.
        drive(1, 2, 3, 18'h100, 2, 8, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        chk("mid_copy1", 64'(cache_instr), 64'(ld_v(STR ? 18'h102 : 18'h100, 8)));
        re = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_empty", 64'(empty), 64'd1);
        chk("rst_mid_cache", 64'(cache_instr), 64'd0);
        chk("rst_mid_arith", 64'(arithmetic_instr), 64'd0);
        step();
        reset = 1'b1;
        drive(1, 2, 1, 18'h40, 8, 9, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("post_rst_copy0", 64'(cache_instr), 64'(ld_v(18'h40, 9)));
        step();
        chk("post_rst_copy1", 64'(cache_instr), 64'(ld_v(STR ? 18'h48 : 18'h40, 9)));
        chk("post_rst_empty", 64'(empty), 64'd1);
        re = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
